// File: rtl/fb_swap_ctrl_pkg.sv
// Shared types and panel constants for the double-buffered frame-buffer controller.
package fb_swap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_WRITE     = 2'd0,
    ST_SWAP_PEND = 2'd1,
    ST_CLEAR     = 2'd2
  } state_e;

  localparam int PANEL_W   = 32;
  localparam int PANEL_H   = 32;
  localparam int SCAN_ROWS = 16;
  localparam int PIX_W     = 3;

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// Game-side port of the frame-buffer controller: pixel writes plus the swap request/ack.
interface fb_swap_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 3
);
  // A write transfers on any rising edge where wr_valid && wr_ready; the game holds
  // wr_addr/wr_data stable while wr_valid is high and wr_ready is low.
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic              swap_req;
  logic              swap_ack;
  logic              busy;

  modport master (
    output wr_valid, wr_addr, wr_data, swap_req,
    input  wr_ready, swap_ack, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, swap_req,
    output wr_ready, swap_ack, busy
  );
endinterface

// File: rtl/fb_bank_mux.sv
// Steers the scanner read path onto the front bank and the write/clear path onto the back bank.
module fb_bank_mux #(
  parameter int ADDR_W = 10,
  parameter int PIX_W  = 3
) (
  input  logic              front_sel,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic [ADDR_W-1:0] back_addr,
  input  logic              back_we,
  input  logic [PIX_W-1:0]  back_wdata,
  output logic [ADDR_W-1:0] b0_addr,
  output logic              b0_we,
  output logic [PIX_W-1:0]  b0_wdata,
  input  logic [PIX_W-1:0]  b0_rdata,
  output logic [ADDR_W-1:0] b1_addr,
  output logic              b1_we,
  output logic [PIX_W-1:0]  b1_wdata,
  input  logic [PIX_W-1:0]  b1_rdata
);

  always_comb begin
    b0_addr  = back_addr;
    b0_we    = back_we;
    b0_wdata = back_wdata;
    b1_addr  = back_addr;
    b1_we    = back_we;
    b1_wdata = back_wdata;
    if (front_sel) begin
      b1_addr = rd_addr;
      b1_we   = 1'b0;
    end else begin
      b0_addr = rd_addr;
      b0_we   = 1'b0;
    end
    // rd_sel lags front_sel by one cycle to match the RAM read latency.
    rd_data = rd_sel ? b1_rdata : b0_rdata;
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Front/back bank owner: swaps only on a scanner frame boundary and optionally clears the new back bank.
module fb_swap_ctrl
  import fb_swap_ctrl_pkg::*;
#(
  parameter int              ADDR_W        = 10,
  parameter int              PIX_W         = 3,
  parameter bit              CLEAR_ON_SWAP = 1'b1,
  parameter logic [PIX_W-1:0] CLEAR_VAL    = '0
) (
  input  logic              clk,
  input  logic              rst,
  fb_swap_ctrl_if.slave     game,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              frame_end,
  output logic              front_sel,
  output logic [ADDR_W-1:0] b0_addr,
  output logic              b0_we,
  output logic [PIX_W-1:0]  b0_wdata,
  input  logic [PIX_W-1:0]  b0_rdata,
  output logic [ADDR_W-1:0] b1_addr,
  output logic              b1_we,
  output logic [PIX_W-1:0]  b1_wdata,
  input  logic [PIX_W-1:0]  b1_rdata,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic              rd_valid_q, rd_valid_d;
  logic              swap_ack_q, swap_ack_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  logic [ADDR_W-1:0] back_addr;
  logic              back_we;
  logic [PIX_W-1:0]  back_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_WRITE;
      front_sel_q <= 1'b0;
      rd_sel_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      swap_ack_q  <= 1'b0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      rd_sel_q    <= rd_sel_d;
      rd_valid_q  <= rd_valid_d;
      swap_ack_q  <= swap_ack_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_ack_d  = 1'b0;
    clr_cnt_d   = clr_cnt_q;
    rd_valid_d  = rd_en;
    rd_sel_d    = front_sel_q;
    back_addr   = game.wr_addr;
    back_wdata  = game.wr_data;
    back_we     = 1'b0;
    unique case (state_q)
      ST_WRITE: begin
        back_we = game.wr_valid;
        // A frame_end arriving with the request is deliberately not a swap point.
        if (game.swap_req) state_d = ST_SWAP_PEND;
      end
      ST_SWAP_PEND: begin
        if (frame_end) begin
          front_sel_d = ~front_sel_q;
          swap_ack_d  = 1'b1;
          state_d     = CLEAR_ON_SWAP ? ST_CLEAR : ST_WRITE;
        end
      end
      ST_CLEAR: begin
        back_we    = 1'b1;
        back_addr  = clr_cnt_q;
        back_wdata = CLEAR_VAL;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = ST_WRITE;
      end
      default: state_d = ST_WRITE;
    endcase
  end

  fb_bank_mux #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_bank_mux (
    .front_sel  (front_sel_q),
    .rd_sel     (rd_sel_q),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .back_addr  (back_addr),
    .back_we    (back_we),
    .back_wdata (back_wdata),
    .b0_addr    (b0_addr),
    .b0_we      (b0_we),
    .b0_wdata   (b0_wdata),
    .b0_rdata   (b0_rdata),
    .b1_addr    (b1_addr),
    .b1_we      (b1_we),
    .b1_wdata   (b1_wdata),
    .b1_rdata   (b1_rdata)
  );

  assign game.wr_ready = (state_q == ST_WRITE);
  assign game.busy     = (state_q != ST_WRITE);
  assign game.swap_ack = swap_ack_q;
  assign rd_valid      = rd_valid_q;
  assign front_sel     = front_sel_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: two behavioural 1-cycle RAMs and per-scenario check tasks.
module tb_fb_swap_ctrl;
  import fb_swap_ctrl_pkg::*;

  localparam int ADDR_W = 10;
  localparam int PW     = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_swap_ctrl_if #(.ADDR_W(ADDR_W), .PIX_W(PW)) game_if ();

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [PW-1:0]     rd_data;
  logic              frame_end;
  logic              front_sel;
  logic [ADDR_W-1:0] b0_addr, b1_addr;
  logic              b0_we, b1_we;
  logic [PW-1:0]     b0_wdata, b1_wdata, b0_rdata, b1_rdata;
  state_e            dbg_state;

  fb_swap_ctrl #(
    .ADDR_W(ADDR_W), .PIX_W(PW), .CLEAR_ON_SWAP(1'b1), .CLEAR_VAL(3'b000)
  ) dut (
    .clk(clk), .rst(rst), .game(game_if),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .frame_end(frame_end), .front_sel(front_sel),
    .b0_addr(b0_addr), .b0_we(b0_we), .b0_wdata(b0_wdata), .b0_rdata(b0_rdata),
    .b1_addr(b1_addr), .b1_we(b1_we), .b1_wdata(b1_wdata), .b1_rdata(b1_rdata),
    .dbg_state(dbg_state)
  );

  logic [PW-1:0] mem0 [DEPTH];
  logic [PW-1:0] mem1 [DEPTH];

  always @(posedge clk) begin
    if (b0_we) mem0[b0_addr] <= b0_wdata;
    if (b1_we) mem1[b1_addr] <= b1_wdata;
    b0_rdata <= mem0[b0_addr];
    b1_rdata <= mem1[b1_addr];
  end

  int            errors = 0;
  int            checks = 0;
  logic          exp_front;
  logic [PW-1:0] exp_q[$];

  // Stimulus changes on the falling edge; the DUT samples it on the next rising edge.
  task automatic do_swap();
    game_if.swap_req = 1'b1;
    @(negedge clk);
    game_if.swap_req = 1'b0;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    exp_front = ~exp_front;
  endtask

  task automatic wait_write(input string name);
    int n;
    n = 0;
    while (dbg_state !== ST_WRITE && n < 1100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== ST_WRITE) begin
      errors++;
      $display("FAIL %s: state=%0d after %0d cycles, required WRITE", name, dbg_state, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_en = 1'b0; rd_addr = '0; frame_end = 1'b0;
    game_if.wr_valid = 1'b0; game_if.wr_addr = '0; game_if.wr_data = '0; game_if.swap_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_front = 1'b0;
    #1;
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL reset_front_sel: got %0b required 0", front_sel); end
    checks++; if (game_if.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %0b required 1", game_if.wr_ready); end
    checks++; if (game_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b required 0", game_if.busy); end
    checks++; if (b0_we !== 1'b0 || b1_we !== 1'b0) begin errors++; $display("FAIL reset_we: got b0=%0b b1=%0b required 0/0", b0_we, b1_we); end
    checks++; if (rd_valid !== 1'b0 || game_if.swap_ack !== 1'b0) begin errors++; $display("FAIL reset_pulses: got rd_valid=%0b swap_ack=%0b required 0/0", rd_valid, game_if.swap_ack); end
    checks++; if (dbg_state !== ST_WRITE) begin errors++; $display("FAIL reset_state: got %0d required WRITE", dbg_state); end
  endtask

  task automatic test_write_read();
    game_if.wr_valid = 1'b1; game_if.wr_addr = 10'd5; game_if.wr_data = 3'b101; rd_addr = 10'd0;
    #1;
    checks++; if (b1_we !== 1'b1 || b1_addr !== 10'd5 || b1_wdata !== 3'b101) begin errors++;
      $display("FAIL wr_back_bank: got we=%0b addr=%0d data=%b required 1/5/101", b1_we, b1_addr, b1_wdata); end
    checks++; if (b0_we !== 1'b0 || b0_addr !== 10'd0) begin errors++;
      $display("FAIL wr_front_bank: got we=%0b addr=%0d required 0/0", b0_we, b0_addr); end
    @(negedge clk);
    game_if.wr_valid = 1'b0;
    checks++; if (mem1[5] !== 3'b101) begin errors++; $display("FAIL wr_commit: got %b required 101", mem1[5]); end
    do_swap();
    wait_write("wr_clear_done");
    rd_en = 1'b1; rd_addr = 10'd5;
    exp_q.push_back(3'b101);
    #1;
    checks++; if (b1_addr !== 10'd5 || b1_we !== 1'b0 || front_sel !== 1'b1) begin errors++;
      $display("FAIL rd_front_addr: got addr=%0d we=%0b front=%0b required 5/0/1", b1_addr, b1_we, front_sel); end
    @(negedge clk);
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin errors++;
      $display("FAIL rd_data: got valid=%0b data=%b required 1/%b", rd_valid, rd_data, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_drop: got %0b required 0", rd_valid); end
  endtask

  task automatic test_swap_timing();
    int bad, bad_idx;
    logic early, ack_after;
    game_if.swap_req = 1'b1;
    @(negedge clk);
    game_if.swap_req = 1'b0;
    checks++; if (game_if.busy !== 1'b1 || game_if.wr_ready !== 1'b0 || dbg_state !== ST_SWAP_PEND) begin errors++;
      $display("FAIL swap_pend_entry: got busy=%0b wr_ready=%0b state=%0d required 1/0/SWAP_PEND", game_if.busy, game_if.wr_ready, dbg_state); end
    early = 1'b0;
    for (int c = 12; c <= 40; c++) begin
      @(negedge clk);
      if (game_if.swap_ack !== 1'b0 || front_sel !== exp_front || dbg_state !== ST_SWAP_PEND) early = 1'b1;
      if (c == 40) frame_end = 1'b1;
    end
    checks++; if (early) begin errors++; $display("FAIL swap_wait: got early swap or state change required hold until frame_end"); end
    @(negedge clk);
    frame_end = 1'b0;
    exp_front = ~exp_front;
    checks++; if (game_if.swap_ack !== 1'b1 || front_sel !== exp_front || dbg_state !== ST_CLEAR) begin errors++;
      $display("FAIL swap_edge: got ack=%0b front=%0b state=%0d required 1/%0b/CLEAR", game_if.swap_ack, front_sel, dbg_state, exp_front); end
    bad = 0; bad_idx = -1; ack_after = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 1) ack_after = game_if.swap_ack;
      if (b1_we !== 1'b1 || b1_addr !== ADDR_W'(i) || b1_wdata !== 3'b000 || b0_we !== 1'b0 || game_if.busy !== 1'b1) begin
        if (bad == 0) bad_idx = i;
        bad++;
      end
      @(negedge clk);
    end
    checks++; if (ack_after !== 1'b0) begin errors++; $display("FAIL swap_ack_width: got ack=%0b one cycle later required 0", ack_after); end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_words: got %0d bad words (first at %0d) required 0", bad, bad_idx); end
    checks++; if (game_if.wr_ready !== 1'b1 || game_if.busy !== 1'b0 || dbg_state !== ST_WRITE) begin errors++;
      $display("FAIL clear_done: got wr_ready=%0b busy=%0b state=%0d required 1/0/WRITE", game_if.wr_ready, game_if.busy, dbg_state); end
    checks++; if (mem1[5] !== 3'b000 || mem1[DEPTH-1] !== 3'b000) begin errors++;
      $display("FAIL clear_contents: got [5]=%b [1023]=%b required 000/000", mem1[5], mem1[DEPTH-1]); end
  endtask

  task automatic test_ignored_request();
    logic seen_ack;
    do_swap();
    repeat (5) @(negedge clk);
    game_if.swap_req = 1'b1;
    @(negedge clk);
    game_if.swap_req = 1'b0;
    checks++; if (dbg_state !== ST_CLEAR) begin errors++; $display("FAIL ign_req_state: got %0d required CLEAR", dbg_state); end
    wait_write("ign_clear_done");
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    seen_ack = game_if.swap_ack;
    repeat (3) begin
      @(negedge clk);
      seen_ack = seen_ack | game_if.swap_ack;
    end
    checks++; if (seen_ack !== 1'b0 || front_sel !== exp_front || dbg_state !== ST_WRITE) begin errors++;
      $display("FAIL ign_no_swap: got ack=%0b front=%0b state=%0d required 0/%0b/WRITE", seen_ack, front_sel, dbg_state, exp_front); end
  endtask

  task automatic test_same_cycle();
    game_if.swap_req = 1'b1; frame_end = 1'b1;
    @(negedge clk);
    game_if.swap_req = 1'b0; frame_end = 1'b0;
    checks++; if (dbg_state !== ST_SWAP_PEND || game_if.swap_ack !== 1'b0 || front_sel !== exp_front) begin errors++;
      $display("FAIL same_cycle_no_swap: got state=%0d ack=%0b front=%0b required SWAP_PEND/0/%0b", dbg_state, game_if.swap_ack, front_sel, exp_front); end
    repeat (3) @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    exp_front = ~exp_front;
    checks++; if (game_if.swap_ack !== 1'b1 || front_sel !== exp_front) begin errors++;
      $display("FAIL same_cycle_later_swap: got ack=%0b front=%0b required 1/%0b", game_if.swap_ack, front_sel, exp_front); end
    wait_write("same_cycle_clear_done");
  endtask

  task automatic test_reset_mid_clear();
    do_swap();
    checks++; if (b0_addr !== 10'd0 || b0_we !== 1'b1 || front_sel !== 1'b1) begin errors++;
      $display("FAIL clr_start: got addr=%0d we=%0b front=%0b required 0/1/1", b0_addr, b0_we, front_sel); end
    repeat (500) @(negedge clk);
    checks++; if (b0_addr !== 10'd500 || dbg_state !== ST_CLEAR) begin errors++;
      $display("FAIL clr_at_500: got addr=%0d state=%0d required 500/CLEAR", b0_addr, dbg_state); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_front = 1'b0;
    checks++; if (dbg_state !== ST_WRITE || front_sel !== exp_front || game_if.wr_ready !== 1'b1 || game_if.busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid_clear: got state=%0d front=%0b wr_ready=%0b busy=%0b required WRITE/0/1/0", dbg_state, front_sel, game_if.wr_ready, game_if.busy); end
    checks++; if (b0_we !== 1'b0 || b1_we !== 1'b0) begin errors++;
      $display("FAIL rst_mid_clear_we: got b0=%0b b1=%0b required 0/0", b0_we, b1_we); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_swap_timing();
    test_ignored_request();
    test_same_cycle();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
- Double-buffered frame-buffer controller between the game logic (writer) and the HUB75 panel scanner (reader) on the 32x32 RGB matrix.
- Owns front/back bank selection over two external single-port pixel RAMs and routes scanner reads to the front bank and game writes to the back bank.
- Swaps banks only at a scanner frame boundary, so the panel never shows a torn frame.
- Optionally auto-clears the new back bank after each swap; sits between the game block and the matrix scanner in the LED top level.

Parameters:
ADDR_W, 10, pixel address width (32x32 = 1024 pixels)
PIX_W, 3, bits per pixel (R,G,B)
CLEAR_ON_SWAP, 1, 1 = clear the new back bank after each swap
CLEAR_VAL, 3'b000, pixel value written during clear

Ports:
clk  in  1  shift/game clock domain; all logic on rising edge
rst  in  1  synchronous, active-high reset
rd_en  in  1  scanner read strobe
rd_addr  in  ADDR_W  scanner pixel address
rd_valid  out  1  rd_data valid; rd_en delayed one cycle
rd_data  out  PIX_W  pixel from front bank
frame_end  in  1  one-cycle pulse from scanner: last row latched
wr_valid  in  1  game write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_W  back-bank pixel address
wr_data  in  PIX_W  pixel value
swap_req  in  1  one-cycle pulse: back frame complete
swap_ack  out  1  one-cycle pulse in the cycle the banks swap
busy  out  1  swap pending or clear in progress
front_sel  out  1  current front bank (0 = bank0)
b0_addr/b1_addr  out  ADDR_W  bank address
b0_we/b1_we  out  1  bank write enable
b0_wdata/b1_wdata  out  PIX_W  bank write data
b0_rdata/b1_rdata  in  PIX_W  bank read data, 1-cycle latency

Behaviour:
- Reset values: front_sel=0, state=WRITE, rd_valid=0, swap_ack=0, busy=0, clear counter=0, b0_we=b1_we=0, wr_ready=1 from the first cycle after reset.
- Reads:
  - Front bank address = rd_addr every cycle; front bank we=0 always.
  - rd_valid = rd_en registered.
  - rd_data = the rdata of the bank selected by a registered copy of front_sel. A read issued in the swap cycle therefore returns old-front data.
- States:
  - WRITE:
    - wr_ready=1; back bank addr/wdata = wr_addr/wr_data; back we = wr_valid.
    - swap_req -> SWAP_PEND. A write in the same cycle is still committed.
  - SWAP_PEND:
    - wr_ready=0, busy=1, back we=0.
    - On frame_end: toggle front_sel next edge and pulse swap_ack in the cycle front_sel changes.
    - Then go to CLEAR if CLEAR_ON_SWAP=1, else WRITE.
    - A frame_end in the same cycle as the swap_req that leaves WRITE does not swap; the block waits for the next frame_end.
  - CLEAR:
    - wr_ready=0, busy=1.
    - Back bank we=1, addr=counter, wdata=CLEAR_VAL; counter 0..2^ADDR_W-1, one word per cycle.
    - After the write of the last address: counter wraps to 0, state -> WRITE.
    - Takes exactly 2^ADDR_W cycles.
- swap_req in SWAP_PEND or CLEAR is ignored (no queueing).
- frame_end outside SWAP_PEND has no effect.
- Bank mux: bank port n is driven from the read path when front_sel==n, otherwise from the write/clear path.
- Reset mid-SWAP_PEND or mid-CLEAR: abort immediately, return to reset values. Back-bank contents are undefined, and the game must redraw.
- No arithmetic beyond the ADDR_W-bit clear counter; counter wrap is natural modulo 2^ADDR_W.

Decomposition:
- Shared package holds:
  - state enum {WRITE, SWAP_PEND, CLEAR}
  - panel constants: PANEL_W=32, PANEL_H=32, SCAN_ROWS=16, PIX_W=3
- One natural sub-module: fb_bank_mux (pure steering of the read path and write/clear path onto b0/b1 by front_sel).
- FSM and counter stay in fb_swap_ctrl.

Test Plan:
- Reset: rst high 2 cycles -> front_sel=0, wr_ready=1, busy=0, b0_we=b1_we=0.
- Write/read path:
  - Write wr_addr=5, wr_data=3'b101 -> b1_we=1, b1_addr=5.
  - Then swap_req, frame_end, wait clear done, rd_en rd_addr=5 -> rd_valid next cycle, rd_data=3'b101 from bank1.
- Swap timing:
  - swap_req at cycle 10, frame_end at cycle 40 -> busy=1 and wr_ready=0 from cycle 11.
  - swap_ack exactly one cycle, front_sel toggles at cycle 41.
  - Same-cycle swap_req+frame_end does not swap.
- Clear:
  - CLEAR_ON_SWAP=1, after swap -> 1024 consecutive back-bank writes of 3'b000 to addresses 0..1023.
  - Then wr_ready=1 and busy=0 on cycle 1025.
- Ignored request: swap_req during CLEAR -> no second swap_ack on the next frame_end; front_sel unchanged.
- Reset mid-clear: assert rst at clear counter=500 -> next cycle state=WRITE, front_sel=0, b0_we=b1_we=0, wr_ready=1.
